fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end of the MIPS pipeline, sitting directly upstream of the datapath's IF/ID register. Owns the PC, issues sequential word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents one instruction per cycle with its PC to the datapath. Handles stall back-pressure and branch/jump redirects, discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, instruction buffer entries and max requests in flight (power of 2, ≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_resp_valid  in  1  response valid; in order, one per accepted request, ≥1 cycle after accept
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  32  redirect target
- stall  in  1  datapath cannot consume this cycle
- ins_valid  out  1  ins/ins_pc hold a valid instruction
- ins  out  32  instruction; 32'h0000_0000 (NOP) when ins_valid=0
- ins_pc  out  32  PC of ins
- fetch_err  out  1  misaligned redirect seen (see Configuration)

## Operation
- State: pc (next request address), FIFO of {data, pc} with DEPTH entries, outstanding counter (0..DEPTH), discard counter (0..DEPTH).
- Issue: imem_req_valid=1 iff not in reset, no fetch_err, no redirect this cycle, and outstanding + occupancy < DEPTH (same-cycle pop not credited). On valid&&ready: outstanding+1, pc+=4 (wraps at 2^32).
- imem_req_addr = pc; stable while valid && !ready.
- Response: if discard>0, decrement discard and drop data; else push {data, pc-of-request} into FIFO, outstanding-1. Request PCs tracked by a parallel PC FIFO/tag, not recomputed.
- Consume: head popped when ins_valid && !stall. ins/ins_pc/ins_valid are registered from the FIFO head.
- Redirect (priority over everything): FIFO cleared; discard += all outstanding not yet answered, including a request accepted this cycle, minus a response arriving this cycle (that response is itself dropped); outstanding reset to 0; pc <= redirect_pc. Redirect during stall also drops the held instruction.
- Never more than DEPTH requests unanswered; FIFO never overflows by construction.

## Timing
- Reset: pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0, fetch_err=0, all counters 0, FIFO empty. Reset mid-transaction abandons in-flight requests; the memory is reset by the same rst.
- First request asserted cycle after rst deasserts.
- Latency: request accepted at T, response at T+L → ins_valid at T+L+1. Steady-state 1 instr/cycle when L+1 < DEPTH and ready=1.
- Redirect at cycle R: imem_req_valid=0 at R, ins_valid=0 at R+1, first request with redirect_pc at R+1.
- Stall held: ins/ins_pc/ins_valid unchanged; fetching continues until FIFO full.
- FIFO empty and !stall: ins_valid drops to 0, ins=NOP next cycle.
- Back-to-back redirects: last one wins; discard accumulates correctly.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets fetch_err (sticky until rst), pc takes the value anyway, imem_req_valid held 0, ins_valid 0 after flush.
- Undefined: redirect_pc[1:0] forced to 2'b00, fetch_err tied 0.

## Test plan
- Reset RESET_PC=0x400, ready=1, L=1, no stall → addresses 0x400,0x404,0x408…; ins_valid first at cycle 3 after reset release, ins_pc tracks in order.
- Stall held 6 cycles with ready=1 → exactly DEPTH=4 requests issued, ins/ins_pc frozen, then 1 instr/cycle on release with no loss/duplication.
- Redirect to 0x1000 with 3 requests in flight (L=3) → those 3 responses dropped, next ins_pc=0x1000, no old instruction appears.
- Redirect in same cycle as a request handshake and a response → both counted stale; ins_pc after redirect starts exactly at target.
- Random ready/resp delays, 1000 instructions → ins stream equals memory model in address order, outstanding never > 4.
- FETCH_ALIGN_CHECK_EN, redirect to 0x1002 → fetch_err=1, no further requests until rst; without macro, fetch from 0x1000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, streams word requests to imem, buffers responses.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_err.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        ins_valid,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic        fetch_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 2;

   logic [31:0]   pc;
   logic [31:0]   target;
   logic [31:0]   tag_mem  [DEPTH];
   logic [31:0]   buf_data [DEPTH];
   logic [31:0]   buf_pc   [DEPTH];
   logic [AW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
   logic [CW-1:0] buf_cnt, outstanding, discard;
   logic [CW-1:0] discard_redirect;
   logic [SW-1:0] inflight;
   logic          req_fire, resp_live, out_free, buf_pop, buf_push, bypass;

   // Stale responses are counted in the issue budget so unanswered requests never exceed DEPTH.
   always_comb begin
      inflight         = SW'(outstanding) + SW'(discard) + SW'(buf_cnt);
      imem_req_valid   = !rst && !fetch_err && !redirect_valid && (inflight < SW'(DEPTH));
      req_fire         = imem_req_valid && imem_req_ready;
      resp_live        = imem_resp_valid && (discard == '0);
      out_free         = !ins_valid || !stall;
      buf_pop          = out_free && (buf_cnt != '0);
      bypass           = out_free && (buf_cnt == '0) && resp_live;
      buf_push         = resp_live && !bypass;
      discard_redirect = CW'(SW'(discard) + SW'(outstanding) + SW'(req_fire)
                             - SW'(imem_resp_valid));
   end

   assign imem_req_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         tag_wr      <= '0;
         tag_rd      <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
         buf_cnt     <= '0;
         outstanding <= '0;
         discard     <= '0;
         ins_valid   <= 1'b0;
         ins         <= '0;
         ins_pc      <= '0;
      end else if (redirect_valid) begin
         pc          <= target;
         tag_wr      <= '0;
         tag_rd      <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
         buf_cnt     <= '0;
         outstanding <= '0;
         discard     <= discard_redirect;
         ins_valid   <= 1'b0;
         ins         <= '0;
      end else begin
         if (req_fire) begin
            tag_mem[tag_wr] <= pc;
            tag_wr          <= tag_wr + AW'(1);
            pc              <= pc + 32'd4;
         end
         // Stale responses predate every tag still queued, so they leave the tag FIFO alone.
         if (imem_resp_valid) begin
            if (discard != '0) discard <= discard - CW'(1);
            else               tag_rd  <= tag_rd + AW'(1);
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_live);

         if (buf_push) begin
            buf_data[buf_wr] <= imem_resp_data;
            buf_pc[buf_wr]   <= tag_mem[tag_rd];
            buf_wr           <= buf_wr + AW'(1);
         end
         if (buf_pop) buf_rd <= buf_rd + AW'(1);
         buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);

         // Output stage refills from the buffer head, or straight from memory when the buffer is empty.
         if (buf_pop) begin
            ins_valid <= 1'b1;
            ins       <= buf_data[buf_rd];
            ins_pc    <= buf_pc[buf_rd];
         end else if (bypass) begin
            ins_valid <= 1'b1;
            ins       <= imem_resp_data;
            ins_pc    <= tag_mem[tag_rd];
         end else if (out_free) begin
            ins_valid <= 1'b0;
            ins       <= '0;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
         err_q <= 1'b1;
   end

   assign fetch_err = err_q;
   assign target    = redirect_pc;
`else
   assign fetch_err = 1'b0;
   assign target    = redirect_pc & 32'hFFFF_FFFC;
`endif

endmodule
